// File: rtl/fazyrv_rf_ctrl.sv
// Chunk-serial register-file sequencer: RUN shifts all regs NCHUNK times, optional WAIT/WB write-back.
// Latency NCHUNK+1 cycles to done_o without stalls; stall_i freezes progress, flush_i aborts to IDLE.
module fazyrv_rf_ctrl #(
  parameter int CHUNKSIZE = 2
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       start_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       wb_i,
  input  logic       ccx_i,
  input  logic       stall_i,
  input  logic       res_vld_i,
  input  logic       flush_i,
  output logic       rdy_o,
  output logic [4:0] rf_rs1_o,
  output logic [4:0] rf_rs2_o,
  output logic [4:0] rf_rd_o,
  output logic       rf_shft_o,
  output logic       rf_shft_rd_o,
  output logic       rf_we_o,
  output logic       first_o,
  output logic       last_o,
  output logic       done_o
);

  localparam int NCHUNK = 32 / CHUNKSIZE;
  localparam int CW     = $clog2(NCHUNK);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_rs1;
  logic [4:0]    r_rs2;
  logic [4:0]    r_rd;
  logic          r_wb;
  logic          r_ccx;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_nxt;
  logic          w_accept;
  logic          w_go;
  logic          w_cnt_last;
  logic          w_rd_nz;
  logic          w_run;
  logic          w_wb;

  assign w_go       = !stall_i && !flush_i;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_rd_nz    = |r_rd;
  assign w_run      = (r_state == S_RUN);
  assign w_wb       = (r_state == S_WB);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_accept    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (!stall_i) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_last) begin
              if (r_ccx) begin
                w_state_nxt = S_WAIT;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          // A deferred result without write-back completes straight from WAIT.
          if (res_vld_i) begin
            w_cnt_nxt = '0;
            if (r_wb) begin
              w_state_nxt = S_WB;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        S_WB: begin
          if (!stall_i) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_last) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_wb    <= 1'b0;
      r_ccx   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_rs1 <= rs1_i;
        r_rs2 <= rs2_i;
        r_rd  <= rd_i;
        r_wb  <= wb_i;
        r_ccx <= ccx_i;
      end
    end
  end

  assign rdy_o        = (r_state == S_IDLE);
  assign rf_rs1_o     = r_rs1;
  assign rf_rs2_o     = r_rs2;
  assign rf_rd_o      = r_rd;
  assign rf_shft_o    = w_run && w_go;
  assign rf_shft_rd_o = w_wb && w_go;
  // x0 is hardwired to zero, so it is never written even while shifting.
  assign rf_we_o      = w_go && w_rd_nz && ((w_run && r_wb && !r_ccx) || w_wb);
  assign first_o      = (w_run || w_wb) && (r_cnt == '0);
  assign last_o       = (w_run || w_wb) && w_cnt_last;
  assign done_o       = r_done;

endmodule

// File: tb/tb_fazyrv_rf_ctrl.sv
// Bench for fazyrv_rf_ctrl: directed scenarios plus random traffic against an operation-level model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_fazyrv_rf_ctrl;

  localparam int N = 16;
  localparam int P_IDLE  = 0;
  localparam int P_CALC  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_WRITE = 3;

  logic       clk_i = 1'b0;
  logic       rst_in, start_i, wb_i, ccx_i, stall_i, res_vld_i, flush_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       rdy_o, rf_shft_o, rf_shft_rd_o, rf_we_o, first_o, last_o, done_o;
  logic [4:0] rf_rs1_o, rf_rs2_o, rf_rd_o;

  always #5 clk_i = ~clk_i;

  fazyrv_rf_ctrl #(.CHUNKSIZE(2)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(start_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .wb_i(wb_i), .ccx_i(ccx_i), .stall_i(stall_i), .res_vld_i(res_vld_i), .flush_i(flush_i),
    .rdy_o(rdy_o), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .rf_rd_o(rf_rd_o),
    .rf_shft_o(rf_shft_o), .rf_shft_rd_o(rf_shft_rd_o), .rf_we_o(rf_we_o),
    .first_o(first_o), .last_o(last_o), .done_o(done_o)
  );

  typedef struct packed {
    logic       rdy, shft, shft_rd, we, first, last, done;
    logic [4:0] rs1, rs2, rd;
  } obs_t;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } req_t;

  obs_t exp_q[$];
  req_t req_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Operation-level model: phase plus shifts remaining in the current phase.
  int         m_phase = P_IDLE;
  int         m_left  = 0;
  logic [4:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  bit         m_wb = 0, m_ccx = 0, m_done = 0;

  task automatic drive(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input logic wb, input logic ccx,
                       input logic stall, input logic rv, input logic fl, input logic rn);
    obs_t e;
    bit   go, nd;
    @(posedge clk_i);
    #1;
    cyc++;
    rst_in = rn; start_i = st; rs1_i = a1; rs2_i = a2; rd_i = ad;
    wb_i = wb; ccx_i = ccx; stall_i = stall; res_vld_i = rv; flush_i = fl;
    e = '0;
    if (!rn) begin
      e.rdy = 1'b1;
      m_phase = P_IDLE; m_left = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      m_wb = 0; m_ccx = 0; m_done = 0;
    end else begin
      go        = !stall && !fl;
      e.rdy     = (m_phase == P_IDLE);
      e.done    = m_done;
      e.rs1     = m_rs1; e.rs2 = m_rs2; e.rd = m_rd;
      e.first   = (m_phase == P_CALC || m_phase == P_WRITE) && m_left == N;
      e.last    = (m_phase == P_CALC || m_phase == P_WRITE) && m_left == 1;
      e.shft    = (m_phase == P_CALC) && go;
      e.shft_rd = (m_phase == P_WRITE) && go;
      e.we      = go && (m_rd != 0) && ((m_phase == P_CALC && m_wb && !m_ccx) || m_phase == P_WRITE);
      nd = 0;
      if (fl) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_IDLE) begin
        if (st) begin
          m_rs1 = a1; m_rs2 = a2; m_rd = ad; m_wb = wb; m_ccx = ccx;
          m_phase = P_CALC; m_left = N;
        end
      end else if (m_phase == P_HOLD) begin
        if (rv) begin
          if (m_wb) begin m_phase = P_WRITE; m_left = N; end
          else begin m_phase = P_IDLE; nd = 1; end
        end
      end else if (!stall) begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == P_CALC && m_ccx) m_phase = P_HOLD;
          else begin m_phase = P_IDLE; nd = 1; end
        end
      end
      m_done = nd;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic push_req(input int kind, input int expv, input string name);
    req_t r;
    r.kind = kind; r.exp = expv; r.name = name;
    req_q.push_back(r);
  endtask

  // Monitor: compares every presented cycle and keeps per-operation measurements.
  initial begin
    obs_t a, e;
    req_t r;
    int   t0 = 0, sh = 0, shrd = 0, wec = 0, dn = 0, dcyc = -1, v;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {rdy_o, rf_shft_o, rf_shft_rd_o, rf_we_o, first_o, last_o, done_o,
             rf_rs1_o, rf_rs2_o, rf_rd_o};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL outputs cycle %0d: got %06h expected %06h", cyc, a, e);
        sh   += int'(a.shft);
        shrd += int'(a.shft_rd);
        wec  += int'(a.we);
        if (a.done) begin
          dn++;
          if (dcyc < 0) dcyc = cyc - t0;
        end
      end
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        if (r.kind == 9) begin
          t0 = cyc; sh = 0; shrd = 0; wec = 0; dn = 0; dcyc = -1;
        end else begin
          case (r.kind)
            0:       v = dcyc;
            1:       v = sh;
            2:       v = shrd;
            3:       v = wec;
            default: v = dn;
          endcase
          n_total++;
          if (v == r.exp) n_pass++;
          else $display("FAIL %s: got %0d expected %0d", r.name, v, r.exp);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b0; start_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
    wb_i = 0; ccx_i = 0; stall_i = 0; res_vld_i = 0; flush_i = 0;
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Plain operation
    drive(1, 3, 4, 5, 1, 0, 0, 0, 0, 1); push_req(9, 0, "");
    idle(18);
    push_req(0, 17, "lat_basic"); push_req(1, 16, "shift_basic"); push_req(3, 16, "we_basic");

    // Stalls on cycles 4..6
    drive(1, 3, 4, 5, 1, 0, 0, 0, 0, 1); push_req(9, 0, "");
    for (int i = 1; i <= 20; i++) drive(0, 0, 0, 0, 0, 0, (i >= 4 && i <= 6), 0, 0, 1);
    idle(1);
    push_req(0, 20, "lat_stall"); push_req(1, 16, "shift_stall"); push_req(3, 16, "we_stall");

    // Deferred result: early res_vld ignored, stall in WAIT ignored, result 5 cycles after RUN
    drive(1, 1, 2, 7, 1, 1, 0, 0, 0, 1); push_req(9, 0, "");
    for (int i = 1; i <= 40; i++) drive(0, 0, 0, 0, 0, 0, (i == 18), (i == 3 || i == 21), 0, 1);
    push_req(0, 38, "lat_ccx"); push_req(1, 16, "shift_ccx");
    push_req(2, 16, "shift_rd_ccx"); push_req(3, 16, "we_ccx");

    // Deferred result without write-back
    drive(1, 6, 6, 6, 0, 1, 0, 0, 0, 1); push_req(9, 0, "");
    for (int i = 1; i <= 20; i++) drive(0, 0, 0, 0, 0, 0, 0, (i == 18), 0, 1);
    push_req(0, 19, "lat_ccx_nowb"); push_req(2, 0, "shift_rd_nowb");

    // rd = 0
    drive(1, 8, 9, 0, 1, 0, 0, 0, 0, 1); push_req(9, 0, "");
    idle(18);
    push_req(0, 17, "lat_rd0"); push_req(1, 16, "shift_rd0"); push_req(3, 0, "we_rd0");

    // Flush at chunk 8, immediate restart, then flush beating start in IDLE
    drive(1, 2, 3, 9, 1, 0, 0, 0, 0, 1); push_req(9, 0, "");
    for (int i = 1; i <= 9; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, (i == 9), 1);
    drive(1, 4, 5, 10, 1, 0, 0, 0, 0, 1);
    push_req(4, 0, "flush_no_done"); push_req(9, 0, "");
    idle(18);
    push_req(0, 17, "lat_after_flush"); push_req(1, 16, "shift_after_flush");
    drive(1, 11, 12, 13, 1, 0, 0, 0, 1, 1); push_req(9, 0, "");
    idle(3);
    push_req(1, 0, "flush_start_idle");

    // Reset at chunk 10
    drive(1, 2, 3, 4, 1, 0, 0, 0, 0, 1); push_req(9, 0, "");
    for (int i = 1; i <= 11; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, (i != 11));
    idle(20);
    push_req(4, 0, "reset_no_done");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rd,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
    end
    idle(2);
    @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fazyrv_rf_ctrl.md
FAZYRV_RF_CTRL -- requirements
Module: fazyrv_rf_ctrl

Interface
REQ-001 Parameter CHUNKSIZE, default 2, data path width per cycle; legal values 1, 2, 4, 8; NCHUNK = 32/CHUNKSIZE.
REQ-002 clk_i  input  1  clock, rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  operation request; accepted only when rdy_o=1.
REQ-005 rs1_i, rs2_i, rd_i  input  5 each  register addresses, sampled on accept.
REQ-006 wb_i  input  1  write-back enable, sampled on accept.
REQ-007 ccx_i  input  1  deferred-result mode, sampled on accept.
REQ-008 stall_i  input  1  freeze chunk progress this cycle.
REQ-009 res_vld_i  input  1  deferred result available (ccx mode only).
REQ-010 flush_i  input  1  abort current operation.
REQ-011 rdy_o  output  1  controller idle, can accept start_i.
REQ-012 rf_rs1_o, rf_rs2_o, rf_rd_o  output  5 each  latched addresses to register file.
REQ-013 rf_shft_o  output  1  shift all registers one chunk.
REQ-014 rf_shft_rd_o  output  1  shift only destination register one chunk.
REQ-015 rf_we_o  output  1  write enable to register file.
REQ-016 first_o, last_o  output  1 each  current chunk is index 0 / NCHUNK-1.
REQ-017 done_o  output  1  one-cycle pulse after final chunk of an operation.

Function
REQ-018 States: IDLE, RUN, WAIT, WB; encoding free.
REQ-019 IDLE: rdy_o=1; start_i=1 latches addresses, wb, ccx; clears chunk counter cnt; next state RUN.
REQ-020 RUN: rf_shft_o = !stall_i; rf_we_o = wb & !ccx & (rd!=0) & !stall_i; cnt increments on each non-stalled cycle.
REQ-021 RUN, non-stalled cycle with cnt=NCHUNK-1: ccx=0 -> IDLE with done_o=1 next cycle; ccx=1 -> WAIT.
REQ-022 WAIT: no shift, rf_we_o=0; res_vld_i=1 clears cnt and moves to WB next cycle; wb=0 in WAIT -> IDLE with done_o pulse on res_vld_i.
REQ-023 WB: rf_shft_rd_o = !stall_i; rf_we_o = (rd!=0) & !stall_i; rf_shft_o=0; cnt=NCHUNK-1 non-stalled -> IDLE, done_o=1 next cycle.
REQ-024 Exactly NCHUNK non-stalled shift cycles occur per RUN and per WB phase; stalled cycles add latency only.
REQ-025 Latency, no stalls: ccx=0 -> done_o asserted NCHUNK+1 cycles after accept; ccx=1 -> done_o NCHUNK+1 cycles after res_vld_i accepted.
REQ-026 first_o = (cnt==0) and last_o = (cnt==NCHUNK-1) in RUN and WB, 0 otherwise.
REQ-027 cnt width log2(NCHUNK); wraps to 0 after NCHUNK-1.
REQ-028 rd=0: rf_we_o never asserted; shift sequencing unchanged.
REQ-029 flush_i has priority over all events: next state IDLE, no done_o, no shift/we in flush cycle.
REQ-030 start_i while rdy_o=0 ignored; start_i and flush_i together in IDLE -> flush wins, stays IDLE.
REQ-031 res_vld_i outside WAIT ignored; stall_i in IDLE/WAIT has no effect.
REQ-032 done_o asserted in the IDLE cycle following completion; a new start_i in that cycle is accepted.
REQ-033 rf_* address outputs hold latched values until next accept.

Reset
REQ-034 rst_in=0 asynchronously: state IDLE, cnt=0, latched addresses 0, wb=ccx=0.
REQ-035 During reset: rdy_o=1, rf_shft_o=rf_shft_rd_o=rf_we_o=0, first_o=last_o=done_o=0.
REQ-036 Reset mid-operation abandons the operation; no done_o on release.

Verification
REQ-037 CHUNKSIZE=2, start rs1=3 rs2=4 rd=5 wb=1 ccx=0 -> 16 cycles rf_shft_o=rf_we_o=1, first_o cycle 1, last_o cycle 16, done_o cycle 17.
REQ-038 Same with stall_i=1 on cycles 4-6 -> shift/we low those cycles, 16 shifts total, done_o cycle 20.
REQ-039 ccx=1 rd=7, res_vld_i 5 cycles after RUN ends -> 16 rf_shft_o, WAIT idle, then 16 rf_shft_rd_o with rf_we_o=1, done_o next.
REQ-040 wb=1 rd=0 -> rf_we_o stays 0 for all 16 shifts, done_o still after 17 cycles.
REQ-041 flush_i at chunk 8 -> IDLE next cycle, rdy_o=1, no done_o; new start accepted immediately.
REQ-042 rst_in low at chunk 10 -> all outputs reset values asynchronously; after release rdy_o=1, no done_o.
